// File: rtl/dma_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// dma_bus_arbiter_if
//   Bundles every bus and handshake signal around dma_bus_arbiter: the CPU
//   memory port, the 8237-style DMA unit's HOLD/HLDA pair and master port,
//   the shared memory/IO bus toward the decode fabric, and the two status
//   outputs (dma_owner, bus_error).
//
//   Modports:
//     slave  - the arbiter's view (takes CPU/DMA requests, drives shared bus)
//     master - the surrounding system's view (CPU, DMA unit, memory fabric)
//
//   Parameter:
//     ADDR_W - word-address width; address buses are [ADDR_W:1]
// ---------------------------------------------------------------------------
interface dma_bus_arbiter_if #(
  parameter int ADDR_W = 19
);
  // CPU memory port
  logic [ADDR_W:1] cpu_m_addr;
  logic [15:0]     cpu_m_data_out;
  logic            cpu_m_access;
  logic            cpu_m_wr_en;
  logic [1:0]      cpu_m_bytesel;
  logic            cpu_m_ack;
  logic [15:0]     cpu_m_data_in;

  // DMA unit HOLD/HLDA and master port
  logic            dma_hold_req;
  logic            dma_hold_ack;
  logic [ADDR_W:1] dma_m_addr;
  logic [15:0]     dma_m_data_out;
  logic            dma_m_access;
  logic            dma_m_wr_en;
  logic [1:0]      dma_m_bytesel;
  logic            dma_m_ack;
  logic [15:0]     dma_m_data_in;

  // Shared memory/IO bus
  logic [ADDR_W:1] m_addr;
  logic [15:0]     m_data_out;
  logic            m_access;
  logic            m_wr_en;
  logic [1:0]      m_bytesel;
  logic            m_ack;
  logic [15:0]     m_data_in;

  // Status
  logic            dma_owner;
  logic            bus_error;

  modport slave (
    input  cpu_m_addr, cpu_m_data_out, cpu_m_access, cpu_m_wr_en, cpu_m_bytesel,
    output cpu_m_ack, cpu_m_data_in,
    input  dma_hold_req,
    output dma_hold_ack,
    input  dma_m_addr, dma_m_data_out, dma_m_access, dma_m_wr_en, dma_m_bytesel,
    output dma_m_ack, dma_m_data_in,
    output m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    input  m_ack, m_data_in,
    output dma_owner, bus_error
  );

  modport master (
    output cpu_m_addr, cpu_m_data_out, cpu_m_access, cpu_m_wr_en, cpu_m_bytesel,
    input  cpu_m_ack, cpu_m_data_in,
    output dma_hold_req,
    input  dma_hold_ack,
    output dma_m_addr, dma_m_data_out, dma_m_access, dma_m_wr_en, dma_m_bytesel,
    input  dma_m_ack, dma_m_data_in,
    input  m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    output m_ack, m_data_in,
    input  dma_owner, bus_error
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dma_bus_arbiter
//   Shares the single memory/IO bus between the CPU memory port and the
//   8237-style DMA unit. The DMA side is granted through a HOLD/HLDA
//   handshake only from IDLE (bus quiescent). DMA bursts are capped at
//   MAX_DMA_BURST acks per grant; when the cap forces a release while HOLD
//   is still asserted, a fairness flag gives the CPU the next grant.
//
//   Ports:
//     clk    - system clock
//     reset  - asynchronous, active-high reset (abandons any transfer, no ack)
//     bus    - dma_bus_arbiter_if.slave: CPU port, DMA HOLD/HLDA + master
//              port, shared bus, dma_owner and bus_error status
//
//   Parameters:
//     MAX_DMA_BURST - max consecutive DMA acks per grant (1..255)
//     ADDR_W        - word-address width; must match the interface
//
//   Build option:
//     DMA_ARB_WATCHDOG_EN - when defined, an 8-bit stall counter aborts a
//       transfer that sees no m_ack: bus_error pulses and the owner gets a
//       synthetic ack with data 16'hFFFF. When undefined, bus_error is tied
//       low and the arbiter waits indefinitely for m_ack.
// ---------------------------------------------------------------------------
module dma_bus_arbiter #(
  parameter int MAX_DMA_BURST = 4,
  parameter int ADDR_W        = 19
) (
  input  logic              clk,
  input  logic              reset,
  dma_bus_arbiter_if.slave  bus
);

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_DMA_BURST);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CPU_XFER    = 3'd1,
    S_DMA_GRANT   = 3'd2,
    S_DMA_XFER    = 3'd3,
    S_DMA_RELEASE = 3'd4
  } state_t;

  state_t          state_q;
  logic [7:0]      burst_cnt_q;
  logic            fair_q;
  logic            hold_ack_q;
  logic            owner_q;

  // Effective completion: real m_ack or a watchdog abort.
  logic            timeout_s;
  logic            xfer_ack_s;
  logic [15:0]     xfer_data_s;
  logic            burst_done_s;

  // Shared-bus mux results and routed acks/data
  logic [ADDR_W:1] m_addr_s;
  logic [15:0]     m_data_out_s;
  logic            m_access_s;
  logic            m_wr_en_s;
  logic [1:0]      m_bytesel_s;
  logic            cpu_ack_s;
  logic [15:0]     cpu_data_s;
  logic            dma_ack_s;
  logic [15:0]     dma_data_s;

  assign xfer_ack_s   = bus.m_ack | timeout_s;
  assign xfer_data_s  = timeout_s ? 16'hFFFF : bus.m_data_in;
  // True on the ack that brings the burst count up to the limit.
  assign burst_done_s = ((burst_cnt_q + 8'd1) == BURST_LIMIT);

  // Arbitration FSM with registered HLDA, owner, burst counter and fairness flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= 8'd0;
      fair_q      <= 1'b0;
      hold_ack_q  <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.dma_hold_req && !fair_q) begin
            state_q <= S_DMA_GRANT;
            owner_q <= 1'b1;
          end else if (bus.cpu_m_access) begin
            state_q <= S_CPU_XFER;
            fair_q  <= 1'b0;
          end else if (bus.dma_hold_req) begin
            state_q <= S_DMA_GRANT;
            owner_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_CPU_XFER: begin
          // One transfer per grant.
          if (xfer_ack_s) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_CPU_XFER;
          end
        end

        S_DMA_GRANT: begin
          // HLDA rises leaving GRANT, so HOLD-to-HLDA is two cycles minimum.
          state_q     <= S_DMA_XFER;
          hold_ack_q  <= 1'b1;
          burst_cnt_q <= 8'd0;
        end

        S_DMA_XFER: begin
          if (xfer_ack_s) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
            if (burst_done_s) begin
              // Forced release; CPU gets priority if DMA still wants the bus.
              state_q    <= S_DMA_RELEASE;
              hold_ack_q <= 1'b0;
              owner_q    <= 1'b0;
              fair_q     <= bus.dma_hold_req;
            end else begin
              state_q <= S_DMA_XFER;
            end
          end else if (!bus.dma_hold_req && !bus.dma_m_access) begin
            // HOLD dropped with nothing in flight: release now. A pending
            // access keeps us here until its ack.
            state_q    <= S_DMA_RELEASE;
            hold_ack_q <= 1'b0;
            owner_q    <= 1'b0;
          end else begin
            state_q <= S_DMA_XFER;
          end
        end

        S_DMA_RELEASE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q    <= S_IDLE;
          hold_ack_q <= 1'b0;
          owner_q    <= 1'b0;
        end
      endcase
    end
  end

  // Shared-bus mux selected by the registered state; acks/data go only to the owner.
  always_comb begin
    m_addr_s     = {ADDR_W{1'b0}};
    m_data_out_s = 16'h0000;
    m_access_s   = 1'b0;
    m_wr_en_s    = 1'b0;
    m_bytesel_s  = 2'b00;
    cpu_ack_s    = 1'b0;
    cpu_data_s   = 16'h0000;
    dma_ack_s    = 1'b0;
    dma_data_s   = 16'h0000;
    case (state_q)
      S_CPU_XFER: begin
        m_addr_s     = bus.cpu_m_addr;
        m_data_out_s = bus.cpu_m_data_out;
        m_access_s   = bus.cpu_m_access;
        m_wr_en_s    = bus.cpu_m_wr_en;
        m_bytesel_s  = bus.cpu_m_bytesel;
        cpu_ack_s    = xfer_ack_s;
        cpu_data_s   = xfer_data_s;
      end
      S_DMA_XFER: begin
        m_addr_s     = bus.dma_m_addr;
        m_data_out_s = bus.dma_m_data_out;
        m_access_s   = bus.dma_m_access;
        m_wr_en_s    = bus.dma_m_wr_en;
        m_bytesel_s  = bus.dma_m_bytesel;
        dma_ack_s    = xfer_ack_s;
        dma_data_s   = xfer_data_s;
      end
      default: begin
        // IDLE, GRANT and RELEASE keep the shared bus quiet and drop stray acks.
        m_addr_s     = {ADDR_W{1'b0}};
        m_data_out_s = 16'h0000;
        m_access_s   = 1'b0;
        m_wr_en_s    = 1'b0;
        m_bytesel_s  = 2'b00;
        cpu_ack_s    = 1'b0;
        cpu_data_s   = 16'h0000;
        dma_ack_s    = 1'b0;
        dma_data_s   = 16'h0000;
      end
    endcase
  end

`ifdef DMA_ARB_WATCHDOG_EN
  logic [7:0] wd_cnt_q;
  logic       stall_s;

  assign stall_s   = ((state_q == S_CPU_XFER) || (state_q == S_DMA_XFER)) &&
                     m_access_s && !bus.m_ack;
  // Abort fires on the stalled cycle that finds the counter saturated.
  assign timeout_s = stall_s && (wd_cnt_q == 8'd255);

  // Stall counter: counts stalled transfer cycles, clears on ack or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= 8'd0;
    end else if (stall_s && !timeout_s) begin
      wd_cnt_q <= wd_cnt_q + 8'd1;
    end else begin
      wd_cnt_q <= 8'd0;
    end
  end

  assign bus.bus_error = timeout_s;
`else
  assign timeout_s     = 1'b0;
  assign bus.bus_error = 1'b0;
`endif

  assign bus.m_addr        = m_addr_s;
  assign bus.m_data_out    = m_data_out_s;
  assign bus.m_access      = m_access_s;
  assign bus.m_wr_en       = m_wr_en_s;
  assign bus.m_bytesel     = m_bytesel_s;
  assign bus.cpu_m_ack     = cpu_ack_s;
  assign bus.cpu_m_data_in = cpu_data_s;
  assign bus.dma_m_ack     = dma_ack_s;
  assign bus.dma_m_data_in = dma_data_s;
  assign bus.dma_hold_ack  = hold_ack_q;
  assign bus.dma_owner     = owner_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_bus_arbiter
//   Directed bench for dma_bus_arbiter (MAX_DMA_BURST=4, ADDR_W=19).
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge. Expected values are hand-derived cycle by cycle.
// ---------------------------------------------------------------------------
module tb_dma_bus_arbiter;

  localparam int ADDR_W        = 19;
  localparam int MAX_DMA_BURST = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  dma_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus_if ();

  dma_bus_arbiter #(
    .MAX_DMA_BURST(MAX_DMA_BURST),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.cpu_m_addr     = 19'h00000;
    bus_if.cpu_m_data_out = 16'h0000;
    bus_if.cpu_m_access   = 1'b0;
    bus_if.cpu_m_wr_en    = 1'b0;
    bus_if.cpu_m_bytesel  = 2'b00;
    bus_if.dma_hold_req   = 1'b0;
    bus_if.dma_m_addr     = 19'h00000;
    bus_if.dma_m_data_out = 16'h0000;
    bus_if.dma_m_access   = 1'b0;
    bus_if.dma_m_wr_en    = 1'b0;
    bus_if.dma_m_bytesel  = 2'b00;
    bus_if.m_ack          = 1'b0;
    bus_if.m_data_in      = 16'h0000;
  endtask

  // Burst/fairness timeline, one bit per cycle
  logic [31:0] hold_v, cpu_v, dma_v, ack_v;
  logic [31:0] exp_hold_ack_v, exp_owner_v, exp_cpu_ack_v;
  int cpu_ack_cnt;
  int dma_ack_cnt;
  int err_cycle;
  int seen_flag;

  initial begin
    #100000;
    $display("FAIL tb_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    idle_inputs();
    #1;
    // Reset state
    check_val("rst_hold_ack", bus_if.dma_hold_ack, 32'd0);
    check_val("rst_owner",    bus_if.dma_owner,    32'd0);
    check_val("rst_m_access", bus_if.m_access,     32'd0);
    check_val("rst_m_addr",   bus_if.m_addr,       32'd0);
    check_val("rst_cpu_ack",  bus_if.cpu_m_ack,    32'd0);
    check_val("rst_bus_err",  bus_if.bus_error,    32'd0);
    step();
    step();
    reset = 1'b0;

    // ---- CPU-only read at 19'h12345, ack in third transfer cycle ----
    bus_if.cpu_m_addr    = 19'h12345;
    bus_if.cpu_m_access  = 1'b1;
    bus_if.cpu_m_wr_en   = 1'b0;
    bus_if.cpu_m_bytesel = 2'b11;
    sample();
    check_val("cpu_rd_idle_m_access", bus_if.m_access, 32'd0);
    step();
    cpu_ack_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      bus_if.m_ack     = (k == 2);
      bus_if.m_data_in = (k == 2) ? 16'hBEEF : 16'h0000;
      sample();
      if (bus_if.cpu_m_ack) cpu_ack_cnt++;
      check_val("cpu_rd_m_access",  bus_if.m_access,     32'd1);
      check_val("cpu_rd_m_addr",    bus_if.m_addr,       32'h12345);
      check_val("cpu_rd_hold_ack",  bus_if.dma_hold_ack, 32'd0);
      if (k == 2) begin
        check_val("cpu_rd_data", bus_if.cpu_m_data_in, 32'hBEEF);
        check_val("cpu_rd_bytesel", bus_if.m_bytesel, 32'h3);
      end
      step();
    end
    idle_inputs();
    sample();
    check_val("cpu_rd_ack_count", cpu_ack_cnt, 32'd1);
    check_val("cpu_rd_back_idle", bus_if.m_access, 32'd0);
    step();

    // ---- DMA hold, two writes, hold drop ----
    bus_if.dma_hold_req = 1'b1;
    sample();
    check_val("dma_hlda_c0", bus_if.dma_hold_ack, 32'd0);
    step();
    sample();
    check_val("dma_hlda_c1",  bus_if.dma_hold_ack, 32'd0);
    check_val("dma_owner_c1", bus_if.dma_owner,    32'd1);
    check_val("dma_grant_quiet", bus_if.m_access,  32'd0);
    step();
    dma_ack_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      bus_if.dma_m_access   = 1'b1;
      bus_if.dma_m_wr_en    = 1'b1;
      bus_if.dma_m_bytesel  = 2'b10;
      bus_if.dma_m_addr     = 19'h00100 + 19'(k);
      bus_if.dma_m_data_out = (k == 0) ? 16'h1111 : 16'h2222;
      bus_if.m_ack          = 1'b1;
      sample();
      if (bus_if.dma_m_ack) dma_ack_cnt++;
      check_val("dma_wr_hlda",     bus_if.dma_hold_ack, 32'd1);
      check_val("dma_wr_addr",     bus_if.m_addr,       32'h00100 + 32'(k));
      check_val("dma_wr_data",     bus_if.m_data_out,   (k == 0) ? 32'h1111 : 32'h2222);
      check_val("dma_wr_wr_en",    bus_if.m_wr_en,      32'd1);
      check_val("dma_wr_bytesel",  bus_if.m_bytesel,    32'h2);
      check_val("dma_wr_no_cpuack", bus_if.cpu_m_ack,   32'd0);
      step();
    end
    idle_inputs();
    sample();
    check_val("dma_wr_ack_count", dma_ack_cnt, 32'd2);
    check_val("dma_drop_hlda_c0", bus_if.dma_hold_ack, 32'd1);
    step();
    sample();
    check_val("dma_drop_hlda_c1",  bus_if.dma_hold_ack, 32'd0);
    check_val("dma_drop_owner_c1", bus_if.dma_owner,    32'd0);
    check_val("dma_release_quiet", bus_if.m_access,     32'd0);
    step();

    // ---- Simultaneous CPU and DMA requests: DMA first ----
    bus_if.cpu_m_addr   = 19'h00AAA;
    bus_if.cpu_m_access = 1'b1;
    bus_if.dma_hold_req = 1'b1;
    sample();
    check_val("sim_idle_m_access", bus_if.m_access, 32'd0);
    step();
    sample();
    check_val("sim_grant_owner", bus_if.dma_owner, 32'd1);
    check_val("sim_grant_cpuack", bus_if.cpu_m_ack, 32'd0);
    step();
    bus_if.dma_m_access = 1'b1;
    bus_if.dma_m_addr   = 19'h00200;
    bus_if.m_ack        = 1'b1;
    bus_if.m_data_in    = 16'h5A5A;
    sample();
    check_val("sim_dma_ack",      bus_if.dma_m_ack,     32'd1);
    check_val("sim_dma_data",     bus_if.dma_m_data_in, 32'h5A5A);
    check_val("sim_cpu_no_ack",   bus_if.cpu_m_ack,     32'd0);
    check_val("sim_cpu_no_data",  bus_if.cpu_m_data_in, 32'h0000);
    step();
    bus_if.dma_m_access = 1'b0;
    bus_if.dma_hold_req = 1'b0;
    bus_if.m_ack        = 1'b0;
    bus_if.m_data_in    = 16'h0000;
    sample();
    step();
    sample();
    check_val("sim_release_hlda", bus_if.dma_hold_ack, 32'd0);
    check_val("sim_release_quiet", bus_if.m_access,    32'd0);
    step();
    sample();
    check_val("sim_idle2_quiet", bus_if.m_access, 32'd0);
    step();
    bus_if.m_ack     = 1'b1;
    bus_if.m_data_in = 16'h1234;
    sample();
    check_val("sim_cpu_m_addr", bus_if.m_addr,        32'h00AAA);
    check_val("sim_cpu_ack",    bus_if.cpu_m_ack,     32'd1);
    check_val("sim_cpu_data",   bus_if.cpu_m_data_in, 32'h1234);
    check_val("sim_cpu_no_dma", bus_if.dma_m_ack,     32'd0);
    step();
    idle_inputs();
    sample();
    step();

    // ---- Long DMA hold vs CPU: burst cap and fairness alternation ----
    hold_v         = 32'h003F_FFFF;
    cpu_v          = 32'h03FF_FFFF;
    dma_v          = 32'h0030_783C;
    ack_v          = 32'h0232_793C;
    exp_hold_ack_v = 32'h0070_783C;
    exp_owner_v    = 32'h0078_7C3E;
    exp_cpu_ack_v  = 32'h0202_0100;
    bus_if.cpu_m_addr = 19'h03000;
    bus_if.dma_m_addr = 19'h04000;
    cpu_ack_cnt = 0;
    dma_ack_cnt = 0;
    for (int c = 0; c < 27; c++) begin
      bus_if.dma_hold_req = hold_v[c];
      bus_if.cpu_m_access = cpu_v[c];
      bus_if.dma_m_access = dma_v[c];
      bus_if.m_ack        = ack_v[c];
      sample();
      if (bus_if.cpu_m_ack) cpu_ack_cnt++;
      if (bus_if.dma_m_ack) dma_ack_cnt++;
      check_val($sformatf("burst_hlda_c%0d", c),    bus_if.dma_hold_ack, 32'(exp_hold_ack_v[c]));
      check_val($sformatf("burst_owner_c%0d", c),   bus_if.dma_owner,    32'(exp_owner_v[c]));
      check_val($sformatf("burst_cpuack_c%0d", c),  bus_if.cpu_m_ack,    32'(exp_cpu_ack_v[c]));
      check_val($sformatf("burst_dmaack_c%0d", c),  bus_if.dma_m_ack,    32'(dma_v[c]));
      check_val($sformatf("burst_access_c%0d", c),  bus_if.m_access,     32'(ack_v[c]));
      step();
    end
    check_val("burst_cpu_total", cpu_ack_cnt, 32'd3);
    check_val("burst_dma_total", dma_ack_cnt, 32'd10);
    idle_inputs();

    // ---- Async reset in the middle of a DMA transfer ----
    bus_if.dma_hold_req = 1'b1;
    sample();
    step();
    sample();
    step();
    bus_if.dma_m_access = 1'b1;
    bus_if.dma_m_wr_en  = 1'b1;
    bus_if.dma_m_addr   = 19'h7FFFF;
    sample();
    check_val("rstmid_pre_access", bus_if.m_access,     32'd1);
    check_val("rstmid_pre_hlda",   bus_if.dma_hold_ack, 32'd1);
    #2;
    reset        = 1'b1;
    bus_if.m_ack = 1'b1;
    #1;
    check_val("rstmid_hlda",    bus_if.dma_hold_ack, 32'd0);
    check_val("rstmid_owner",   bus_if.dma_owner,    32'd0);
    check_val("rstmid_access",  bus_if.m_access,     32'd0);
    check_val("rstmid_addr",    bus_if.m_addr,       32'd0);
    check_val("rstmid_wr_en",   bus_if.m_wr_en,      32'd0);
    check_val("rstmid_dma_ack", bus_if.dma_m_ack,    32'd0);
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    bus_if.cpu_m_addr   = 19'h00055;
    bus_if.cpu_m_access = 1'b1;
    sample();
    check_val("rstmid_idle_access", bus_if.m_access, 32'd0);
    step();
    bus_if.m_ack     = 1'b1;
    bus_if.m_data_in = 16'hCAFE;
    sample();
    check_val("rstmid_cpu_access", bus_if.m_access,      32'd1);
    check_val("rstmid_cpu_ack",    bus_if.cpu_m_ack,     32'd1);
    check_val("rstmid_cpu_data",   bus_if.cpu_m_data_in, 32'hCAFE);
    step();
    idle_inputs();
    sample();
    step();

    // ---- Stalled CPU access (watchdog abort or indefinite wait) ----
    bus_if.cpu_m_addr   = 19'h00777;
    bus_if.cpu_m_access = 1'b1;
    sample();
    step();
`ifdef DMA_ARB_WATCHDOG_EN
    err_cycle = 0;
    for (int k = 1; k <= 300 && err_cycle == 0; k++) begin
      sample();
      if (bus_if.bus_error) begin
        err_cycle = k;
        check_val("wd_cpu_ack",  bus_if.cpu_m_ack,     32'd1);
        check_val("wd_cpu_data", bus_if.cpu_m_data_in, 32'hFFFF);
      end
      step();
    end
    check_val("wd_err_cycle", err_cycle, 32'd256);
    bus_if.cpu_m_access = 1'b0;
    sample();
    check_val("wd_back_idle", bus_if.m_access, 32'd0);
    step();
`else
    seen_flag = 0;
    for (int k = 1; k <= 300; k++) begin
      sample();
      if (bus_if.bus_error || bus_if.cpu_m_ack) seen_flag = 1;
      step();
    end
    check_val("nowd_no_abort",   seen_flag,       32'd0);
    bus_if.m_ack     = 1'b1;
    bus_if.m_data_in = 16'h0F0F;
    sample();
    check_val("nowd_still_access", bus_if.m_access,      32'd1);
    check_val("nowd_late_ack",     bus_if.cpu_m_ack,     32'd1);
    check_val("nowd_late_data",    bus_if.cpu_m_data_in, 32'h0F0F);
    check_val("nowd_bus_error",    bus_if.bus_error,     32'd0);
    step();
    idle_inputs();
    sample();
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares the single memory/IO bus between the CPU memory port and the DMA unit's master port. The DMA unit is the 8237-style controller with its page registers.
- Implements the HOLD/HLDA handshake the DMA unit expects, so transfers are only granted when the bus is quiescent.
- Bounds DMA burst length so the CPU cannot be starved.
- Sits between the CPU bus interface, the DMA unit and the memory/IO decode fabric.

Parameters:
- MAX_DMA_BURST, 4: maximum consecutive DMA acks per grant before a forced release (1..255).
- ADDR_W, 19: word-address width; address buses are [ADDR_W:1].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_m_addr  in  ADDR_W  CPU address
- cpu_m_data_out  in  16  CPU write data
- cpu_m_access  in  1  CPU request; held high until cpu_m_ack
- cpu_m_wr_en  in  1  CPU write
- cpu_m_bytesel  in  2  CPU byte mask
- cpu_m_ack  out  1  CPU completion pulse
- cpu_m_data_in  out  16  CPU read data
- dma_hold_req  in  1  DMA HOLD request
- dma_hold_ack  out  1  HLDA to the DMA unit
- dma_m_addr  in  ADDR_W  DMA address
- dma_m_data_out  in  16  DMA write data
- dma_m_access  in  1  DMA request
- dma_m_wr_en  in  1  DMA write
- dma_m_bytesel  in  2  DMA byte mask
- dma_m_ack  out  1  DMA completion pulse
- dma_m_data_in  out  16  DMA read data
- m_addr  out  ADDR_W  shared bus address
- m_data_out  out  16  shared bus write data
- m_access  out  1  shared bus request
- m_wr_en  out  1  shared bus write
- m_bytesel  out  2  shared bus byte mask
- m_ack  in  1  shared bus completion pulse
- m_data_in  in  16  shared bus read data
- dma_owner  out  1  1 while the DMA side owns the bus
- bus_error  out  1  watchdog abort pulse (see Optional Feature)

Behaviour:
- States: IDLE, CPU_XFER, DMA_GRANT, DMA_XFER, DMA_RELEASE.
- Reset (async): state IDLE. All outputs 0. Burst counter 0. Fairness flag 0. Reset mid-transfer abandons the transfer, and no ack is issued.
- IDLE, arbitration each cycle:
  - If dma_hold_req and no fairness flag: go to DMA_GRANT.
  - Else if cpu_m_access: go to CPU_XFER.
  - Else if dma_hold_req: go to DMA_GRANT.
  - Else: stay in IDLE.
  - If both requests are seen with the fairness flag set, the CPU wins; the flag clears on entering CPU_XFER.
- CPU_XFER:
  - Shared bus outputs = CPU inputs, registered-select combinational mux; m_access = cpu_m_access.
  - cpu_m_ack = m_ack in the same cycle. cpu_m_data_in = m_data_in.
  - On m_ack, go to IDLE. One transfer per grant.
- DMA_GRANT: dma_hold_ack = 1 from this state onward (registered, 1 cycle after the IDLE decision). Counter cleared. dma_owner = 1. Next state DMA_XFER.
- DMA_XFER:
  - Bus outputs = DMA inputs; m_access = dma_m_access.
  - dma_m_ack = m_ack; each ack increments the counter.
  - Go to DMA_RELEASE when dma_hold_req drops while no access is pending.
  - Also go to DMA_RELEASE on the ack that makes the counter reach MAX_DMA_BURST; set the fairness flag if dma_hold_req is still high.
- DMA_RELEASE: dma_hold_ack = 0 and dma_owner = 0 (both deasserted on entry). Bus outputs driven 0. Next state IDLE.
- If dma_hold_req drops while dma_m_access is high, the arbiter finishes that access before releasing.
- Ack routing:
  - A CPU ack is never issued when the DMA side owns the bus, and vice versa.
  - m_ack outside CPU_XFER/DMA_XFER is ignored.
  - Non-owner data_in outputs = 0.
- Latency:
  - CPU request from IDLE: m_access asserted 1 cycle after cpu_m_access.
  - HOLD to HLDA: 2 cycles minimum (IDLE, then DMA_GRANT).
- In IDLE and DMA_RELEASE, m_access, m_wr_en and m_bytesel are 0.

Optional Feature:
- Macro: DMA_ARB_WATCHDOG_EN.
- Defined:
  - An 8-bit counter runs in CPU_XFER/DMA_XFER while m_access=1 and m_ack=0, cleared on ack.
  - When the counter reaches 255, bus_error pulses 1 cycle and a synthetic ack is delivered to the owner (data 16'hFFFF).
  - CPU_XFER then goes to IDLE. DMA_XFER treats it as an ack, including the burst count.
- Undefined: no counter, bus_error tied 0, the arbiter waits indefinitely for m_ack.

Test Plan:
- CPU-only read at addr 19'h12345; memory acks after 3 cycles with 16'hBEEF -> m_addr=19'h12345, cpu_m_ack pulses once, cpu_m_data_in=16'hBEEF, dma_hold_ack stays 0.
- DMA hold with 2 writes then hold drop (MAX_DMA_BURST=4) -> hold_ack rises 2 cycles after hold_req, 2 dma_m_acks, hold_ack falls 1 cycle after hold_req drops, state returns to IDLE.
- Simultaneous cpu_m_access and dma_hold_req from IDLE -> DMA granted first; CPU serviced only after DMA_RELEASE.
- DMA keeps hold_req high for 10 transfers while the CPU requests -> hold_ack drops after 4 acks, CPU completes 1 transfer, then hold_ack reasserts; pattern repeats.
- Async reset asserted mid-DMA_XFER -> all outputs 0 immediately; no dma_m_ack; IDLE after reset release.
- With DMA_ARB_WATCHDOG_EN, CPU access never acked -> bus_error and cpu_m_ack pulse together after 255 stalled cycles, cpu_m_data_in=16'hFFFF.
